// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the ALU port in the multicycle CPU.
// Accepts one request at a time, drives the combinational ALU from registers,
// captures Out/Flags and holds the response until consumed.
// MUL is an iterative shift-add that reuses the ALU adder.
// Build option: define MUL_EARLY_EXIT_EN to end MUL once the multiplier is exhausted.
module alu_op_sequencer #(
    parameter int DIGIT    = 32,
    parameter int CTRLSIZE = 4,
    parameter int FLAGSIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [2:0]          ReqOp,
    input  logic [DIGIT-1:0]    ReqA,
    input  logic [DIGIT-1:0]    ReqB,
    output logic [CTRLSIZE-1:0] AluControl,
    output logic [DIGIT-1:0]    AluA,
    output logic [DIGIT-1:0]    AluB,
    input  logic [DIGIT-1:0]    AluOut,
    input  logic [FLAGSIZE-1:0] AluFlags,
    output logic                RespValid,
    input  logic                RespReady,
    output logic [DIGIT-1:0]    RespResult,
    output logic [FLAGSIZE-1:0] RespFlags,
    output logic                RespTaken
);

    localparam int CNTW = (DIGIT > 1) ? $clog2(DIGIT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SLTS = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    localparam logic [CTRLSIZE-1:0] CTRL_ADD = CTRLSIZE'(4'b0000);
    localparam logic [CTRLSIZE-1:0] CTRL_SUB = CTRLSIZE'(4'b0001);
    localparam logic [CTRLSIZE-1:0] CTRL_AND = CTRLSIZE'(4'b1000);
    localparam logic [CTRLSIZE-1:0] CTRL_XOR = CTRLSIZE'(4'b1100);

    // Flag order is {Carry_Borrow, Negative, Overflow, Zero}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 2;

    logic [1:0]          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [CTRLSIZE-1:0] ctrl_q, ctrl_d;
    // During MUL, alu_a_q holds the accumulator and alu_b_q the shifted multiplicand.
    logic [DIGIT-1:0]    alu_a_q, alu_a_d;
    logic [DIGIT-1:0]    alu_b_q, alu_b_d;
    logic [DIGIT-1:0]    mplier_q, mplier_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [DIGIT-1:0]    result_q, result_d;
    logic [FLAGSIZE-1:0] flags_q, flags_d;
    logic                taken_q, taken_d;

    logic [DIGIT-1:0]    acc_next;
    logic [DIGIT-1:0]    mplier_next;
    logic                mul_last;

    function automatic logic [CTRLSIZE-1:0] ctrl_for(input logic [2:0] op);
        case (op)
            OP_ADD, OP_MUL:                  ctrl_for = CTRL_ADD;
            OP_SUB, OP_SLTS, OP_BEQ, OP_BLT: ctrl_for = CTRL_SUB;
            OP_AND:                          ctrl_for = CTRL_AND;
            OP_XOR:                          ctrl_for = CTRL_XOR;
            default:                         ctrl_for = CTRL_ADD;
        endcase
    endfunction

    // Shift-add step: ALU computes acc + mcand; keep it only when the current multiplier bit is set
    always_comb begin
        acc_next    = mplier_q[0] ? AluOut : alu_a_q;
        mplier_next = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
        mul_last    = (cnt_q == CNTW'(DIGIT - 1)) || (mplier_next == '0);
`else
        mul_last    = (cnt_q == CNTW'(DIGIT - 1));
`endif
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ctrl_d   = ctrl_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        taken_d  = taken_q;

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    op_d   = ReqOp;
                    ctrl_d = ctrl_for(ReqOp);
                    if (ReqOp == OP_MUL) begin
                        alu_a_d  = '0;
                        alu_b_d  = ReqA;
                        mplier_d = ReqB;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        alu_a_d = ReqA;
                        alu_b_d = ReqB;
                        state_d = EXEC;
                    end
                end
            end

            EXEC: begin
                flags_d = AluFlags;
                if (op_q == OP_SLTS) begin
                    result_d = {{(DIGIT-1){1'b0}}, AluFlags[FLAG_N]};
                end else begin
                    result_d = AluOut;
                end
                case (op_q)
                    OP_BEQ:  taken_d = AluFlags[FLAG_Z];
                    OP_BLT:  taken_d = AluFlags[FLAG_N];
                    default: taken_d = 1'b0;
                endcase
                ctrl_d  = '0;
                alu_a_d = '0;
                alu_b_d = '0;
                state_d = DONE;
            end

            MUL: begin
                mplier_d = mplier_next;
                cnt_d    = cnt_q + CNTW'(1);
                if (mul_last) begin
                    result_d = acc_next;
                    flags_d  = {{(FLAGSIZE-1){1'b0}}, (acc_next == '0)};
                    taken_d  = 1'b0;
                    ctrl_d   = '0;
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    state_d  = DONE;
                end else begin
                    alu_a_d = acc_next;
                    alu_b_d = alu_b_q << 1;
                end
            end

            DONE: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            ctrl_q   <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ctrl_q   <= ctrl_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            taken_q  <= taken_d;
        end
    end

    // Handshake decodes and registered output drive
    always_comb begin
        ReqReady   = (state_q == IDLE);
        RespValid  = (state_q == DONE);
        AluControl = ctrl_q;
        AluA       = alu_a_q;
        AluB       = alu_b_q;
        RespResult = result_q;
        RespFlags  = flags_q;
        RespTaken  = taken_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU closes the loop, a scoreboard
// queue holds expected responses, directed steps run in one initial block.
module tb_alu_op_sequencer;

    localparam int DIGIT    = 32;
    localparam int CTRLSIZE = 4;
    localparam int FLAGSIZE = 4;

    logic                clk;
    logic                rst_n;
    logic                ReqValid;
    logic                ReqReady;
    logic [2:0]          ReqOp;
    logic [DIGIT-1:0]    ReqA;
    logic [DIGIT-1:0]    ReqB;
    logic [CTRLSIZE-1:0] AluControl;
    logic [DIGIT-1:0]    AluA;
    logic [DIGIT-1:0]    AluB;
    logic [DIGIT-1:0]    AluOut;
    logic [FLAGSIZE-1:0] AluFlags;
    logic                RespValid;
    logic                RespReady;
    logic [DIGIT-1:0]    RespResult;
    logic [FLAGSIZE-1:0] RespFlags;
    logic                RespTaken;

    alu_op_sequencer #(
        .DIGIT   (DIGIT),
        .CTRLSIZE(CTRLSIZE),
        .FLAGSIZE(FLAGSIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqA      (ReqA),
        .ReqB      (ReqB),
        .AluControl(AluControl),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluOut    (AluOut),
        .AluFlags  (AluFlags),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespResult(RespResult),
        .RespFlags (RespFlags),
        .RespTaken (RespTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; flags {C/borrow, N (overflow-corrected), V, Z}
    function automatic logic [35:0] alu_model(input logic [3:0] ctrl, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] o;
        logic        c;
        logic        v;
        logic        n;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (ctrl)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, b};
                o = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (o[31] != a[31]);
            end
            4'b0001: begin
                o = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (o[31] != a[31]);
            end
            4'b1000: o = a & b;
            4'b1100: o = a ^ b;
            default: o = '0;
        endcase
        n = o[31] ^ v;
        return {c, n, v, (o == 32'd0), o};
    endfunction

    assign {AluFlags, AluOut} = alu_model(AluControl, AluA, AluB);

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        taken;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected MUL latency from the multiplier operand
    function automatic int mul_lat(input logic [31:0] b);
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
`ifdef MUL_EARLY_EXIT_EN
        return h + 1;
`else
        return (h >= 0) ? 32 : 0;
`endif
    endfunction

    // Issue one request, wait for the response, hold backpressure 'hold' cycles, then consume
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] ctrl, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [31:0] er, input logic [3:0] ef,
                          input logic et, input int lat, input int hold);
        exp_t e;
        int   cyc;
        chk({tag, ".req_ready"}, 32'(ReqReady), 32'd1);
        ReqValid = 1'b1;
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        e.result = er;
        e.flags  = ef;
        e.taken  = et;
        e.lat    = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        chk({tag, ".busy_ready"}, 32'(ReqReady), 32'd0);
        chk({tag, ".alu_ctrl"}, 32'(AluControl), 32'(ctrl));
        chk({tag, ".alu_a"}, AluA, ea);
        chk({tag, ".alu_b"}, AluB, eb);
        cyc = 0;
        while (RespValid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, ".result"}, RespResult, e.result);
        chk({tag, ".flags"}, 32'(RespFlags), 32'(e.flags));
        chk({tag, ".taken"}, 32'(RespTaken), 32'(e.taken));
        chk({tag, ".done_ctrl"}, 32'(AluControl), 32'd0);
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'b1;
            ReqOp    = 3'b000;
            ReqA     = 32'h1111_1111;
            ReqB     = 32'h2222_2222;
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'(RespValid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(ReqReady), 32'd0);
            chk({tag, ".hold_result"}, RespResult, e.result);
            chk({tag, ".hold_flags"}, 32'(RespFlags), 32'(e.flags));
        end
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        @(posedge clk);
        #1;
        RespReady = 1'b0;
        chk({tag, ".released_valid"}, 32'(RespValid), 32'd0);
        chk({tag, ".released_ready"}, 32'(ReqReady), 32'd1);
    endtask

    logic [31:0] prod;

    initial begin
        rst_n     = 1'b0;
        ReqValid  = 1'b0;
        ReqOp     = '0;
        ReqA      = '0;
        ReqB      = '0;
        RespReady = 1'b0;
        #12;
        chk("reset.req_ready", 32'(ReqReady), 32'd1);
        chk("reset.resp_valid", 32'(RespValid), 32'd0);
        chk("reset.alu_ctrl", 32'(AluControl), 32'd0);
        chk("reset.resp_result", RespResult, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add", 3'b000, 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'hFFFF_FFFF, 32'h1,
               32'h0, 4'b1001, 1'b0, 1, 0);
        run_op("sub", 3'b001, 32'd10, 32'd3, 4'b0001, 32'd10, 32'd3,
               32'd7, 4'b0000, 1'b0, 1, 0);
        run_op("slts", 3'b010, 32'h8000_0000, 32'h1, 4'b0001, 32'h8000_0000, 32'h1,
               32'h1, 4'b0110, 1'b0, 1, 0);
        run_op("beq", 3'b011, 32'd5, 32'd5, 4'b0001, 32'd5, 32'd5,
               32'h0, 4'b0001, 1'b1, 1, 0);
        run_op("blt_t", 3'b100, 32'd3, 32'd7, 4'b0001, 32'd3, 32'd7,
               32'hFFFF_FFFC, 4'b1100, 1'b1, 1, 0);
        run_op("blt_nt", 3'b100, 32'd7, 32'd3, 4'b0001, 32'd7, 32'd3,
               32'd4, 4'b0000, 1'b0, 1, 0);
        run_op("and", 3'b110, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b1000, 32'hF0F0_FF00,
               32'h0FF0_F0F0, 32'h00F0_F000, 4'b0000, 1'b0, 1, 0);
        run_op("xor", 3'b111, 32'hFFFF_0000, 32'h0000_FFFF, 4'b1100, 32'hFFFF_0000,
               32'h0000_FFFF, 32'hFFFF_FFFF, 4'b0100, 1'b0, 1, 0);
        run_op("mul_1234", 3'b101, 32'h1234, 32'h10, 4'b0000, 32'h0, 32'h1234,
               32'h0001_2340, 4'b0000, 1'b0, mul_lat(32'h10), 3);
        run_op("mul_wrap", 3'b101, 32'h8000_0000, 32'h2, 4'b0000, 32'h0, 32'h8000_0000,
               32'h0, 4'b0001, 1'b0, mul_lat(32'h2), 0);
        run_op("mul_zero", 3'b101, 32'h55, 32'h0, 4'b0000, 32'h0, 32'h55,
               32'h0, 4'b0001, 1'b0, mul_lat(32'h0), 0);
        prod = 32'h1234_5678 * 32'h9ABC_DEF0;
        run_op("mul_big", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0000, 32'h0,
               32'h1234_5678, prod, {3'b000, (prod == 32'd0)}, 1'b0,
               mul_lat(32'h9ABC_DEF0), 0);

        // Abort a multiply in flight with reset
        ReqValid = 1'b1;
        ReqOp    = 3'b101;
        ReqA     = 32'd7;
        ReqB     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.busy", 32'(RespValid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort.req_ready", 32'(ReqReady), 32'd1);
        chk("abort.resp_valid", 32'(RespValid), 32'd0);
        chk("abort.alu_ctrl", 32'(AluControl), 32'd0);
        chk("abort.alu_a", AluA, 32'd0);
        chk("abort.alu_b", AluB, 32'd0);
        chk("abort.result", RespResult, 32'd0);
        chk("abort.flags", 32'(RespFlags), 32'd0);
        chk("abort.taken", 32'(RespTaken), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("add_after_rst", 3'b000, 32'd2, 32'd3, 4'b0000, 32'd2, 32'd3,
               32'd5, 4'b0000, 1'b0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
